// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB-first, start/busy/done handshake.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a-b (two's complement).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;

  // Subtraction is a+~b+1: invert b and force the carry flop to 1 at capture.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_load = sub ? ~b : b;
    c_load = sub ? 1'b1 : cin;
`else
    b_load = b;
    c_load = cin;
`endif
  end

  always_comb begin
    fa_s     = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    fa_c     = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b_load;
          c_d     = c_load;
          cnt_d   = '0;
          state_d = S_ADD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADD: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        c_d    = fa_c;
        // Result fills from the MSB end so the final bit lands it fully aligned.
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = fa_s;
        cnt_d            = cnt_q + CW'(1);
        if (last_bit) begin
          sum_d   = res_d;
          cout_d  = fa_c;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == S_ADD);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
